// File: rtl/pc_redirect_ctrl.sv
// Fetch PC-source controller: decodes JAL/branch/JALR, redirects in the decision cycle, then stalls for FLUSH_CYCLES.
// Decision outputs are combinational; hold freezes the flush countdown and blocks new redirects.
module pc_redirect_ctrl #(
  parameter int XLEN         = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             hold,
  input  logic [1:0]       op1,
  input  logic [2:0]       op2,
  input  logic [3:0]       op3,
  input  logic [2:0]       cond,
  input  logic             S,
  input  logic             Zero,
  input  logic             C,
  input  logic             V,
  input  logic [XLEN-1:0]  pc_rel_target,
  input  logic [XLEN-1:0]  reg_target,
  output logic [1:0]       PCsrc,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             stall,
  output logic             flushing,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [3:0] LP_FLUSH     = 4'(FLUSH_CYCLES);
  localparam bit         LP_HAS_FLUSH = (FLUSH_CYCLES != 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [CNT_W-1:0] r_count;

  logic w_cond_true;
  logic w_is_jal;
  logic w_is_br;
  logic w_is_jalr;
  logic w_take;

  always_comb begin
    w_cond_true = 1'b0;
    case (cond)
      3'b000:  w_cond_true = Zero;
      3'b001:  w_cond_true = S ^ V;
      3'b010:  w_cond_true = Zero | (S ^ V);
      3'b011:  w_cond_true = ~Zero;
      3'b100:  w_cond_true = C;
      3'b101:  w_cond_true = ~C;
      3'b110:  w_cond_true = V;
      default: w_cond_true = 1'b1;
    endcase
  end

  assign w_is_jal  = (op1 == 2'b10) && (op2 == 3'b100);
  assign w_is_br   = (op1 == 2'b10) && (op2 == 3'b111) && w_cond_true;
  assign w_is_jalr = (op1 == 2'b11) && (op3 == 4'b1110);

  // Only IDLE can take: anything decoded during FLUSH is on the wrong path.
  assign w_take = (r_state == IDLE) && valid && !hold && (w_is_jal || w_is_br || w_is_jalr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    PCsrc       = 2'b00;
    redirect    = 1'b0;
    redirect_pc = '0;
    stall       = 1'b0;
    flushing    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          redirect = 1'b1;
          stall    = 1'b1;
          if (w_is_jalr) begin
            PCsrc       = 2'b10;
            redirect_pc = reg_target;
          end else begin
            PCsrc       = 2'b01;
            redirect_pc = pc_rel_target;
          end
          if (LP_HAS_FLUSH) begin
            w_state_nxt = FLUSH;
            w_cnt_nxt   = LP_FLUSH;
          end
        end
      end
      FLUSH: begin
        stall    = 1'b1;
        flushing = 1'b1;
        if (!hold) begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_take && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign redirect_count = r_count;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: one instance with a 2-cycle flush, one with no flush and a 2-bit counter.
module tb_pc_redirect_ctrl;

  typedef struct packed {
    logic [1:0]  pcsrc;
    logic        red;
    logic [15:0] rpc;
    logic        stall;
    logic        fl;
    logic [15:0] cnt;
  } exp_t;

  typedef struct packed {
    logic [2:0] op2;
    logic [2:0] cond;
    logic       s;
    logic       z;
    logic       c;
    logic       v;
    logic       tk;
  } br_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        valid1 = 1'b0;
  logic        hold = 1'b0;
  logic [1:0]  op1 = 2'b00;
  logic [2:0]  op2 = 3'b000;
  logic [3:0]  op3 = 4'b0000;
  logic [2:0]  cond = 3'b000;
  logic        s_f = 1'b0, z_f = 1'b0, c_f = 1'b0, v_f = 1'b0;
  logic [15:0] prel = 16'h0;
  logic [15:0] rtgt = 16'h0;

  logic [1:0]  pcsrc0, pcsrc1;
  logic        red0, red1, stall0, stall1, fl0, fl1;
  logic [15:0] rpc0, rpc1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.XLEN(16), .FLUSH_CYCLES(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .valid(valid), .hold(hold),
    .op1(op1), .op2(op2), .op3(op3), .cond(cond),
    .S(s_f), .Zero(z_f), .C(c_f), .V(v_f),
    .pc_rel_target(prel), .reg_target(rtgt),
    .PCsrc(pcsrc0), .redirect(red0), .redirect_pc(rpc0),
    .stall(stall0), .flushing(fl0), .redirect_count(cnt0)
  );

  pc_redirect_ctrl #(.XLEN(16), .FLUSH_CYCLES(0), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .valid(valid1), .hold(hold),
    .op1(op1), .op2(op2), .op3(op3), .cond(cond),
    .S(s_f), .Zero(z_f), .C(c_f), .V(v_f),
    .pc_rel_target(prel), .reg_target(rtgt),
    .PCsrc(pcsrc1), .redirect(red1), .redirect_pc(rpc1),
    .stall(stall1), .flushing(fl1), .redirect_count(cnt1)
  );

  function automatic exp_t mk(input logic [1:0] p, input logic r, input logic [15:0] pc,
                              input logic st, input logic f, input logic [15:0] c);
    exp_t e;
    e.pcsrc = p; e.red = r; e.rpc = pc; e.stall = st; e.fl = f; e.cnt = c;
    return e;
  endfunction

  function automatic exp_t obs0();
    return mk(pcsrc0, red0, rpc0, stall0, fl0, cnt0);
  endfunction

  function automatic exp_t obs1();
    return mk(pcsrc1, red1, rpc1, stall1, fl1, {14'd0, cnt1});
  endfunction

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] o1, input logic [2:0] o2, input logic [3:0] o3, input logic [2:0] cd);
    op1 = o1; op2 = o2; op3 = o3; cond = cd;
  endtask

  task automatic test_reset();
    exp_t e, o;
    for (int i = 0; i < 6; i++) begin
      cyc_start();
      case (i)
        0: begin rst = 1'b1; valid = 1'b0; q0.push_back(mk(2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 16'd0)); end
        1: begin rst = 1'b0; valid = 1'b1; set_op(2'b10, 3'b100, 4'h0, 3'b000); prel = 16'h0040;
                 q0.push_back(mk(2'b01, 1'b1, 16'h0040, 1'b1, 1'b0, 16'd0)); end
        2: begin valid = 1'b0; q0.push_back(mk(2'b00, 1'b0, 16'h0, 1'b1, 1'b1, 16'd1)); end
        3: begin rst = 1'b1; q0.push_back(mk(2'b00, 1'b0, 16'h0, 1'b1, 1'b1, 16'd1)); end
        4: begin rst = 1'b1; q0.push_back(mk(2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 16'd0)); end
        default: begin rst = 1'b0; q0.push_back(mk(2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 16'd0)); end
      endcase
      @(negedge clk);
      e = q0.pop_front(); o = obs0();
      checks++;
      if (o !== e) begin failures++; $display("FAIL reset cyc%0d: got %h want %h", i, o, e); end
    end
    exp_cnt = 0;
  endtask

  task automatic test_jal();
    exp_t e, o;
    for (int i = 0; i < 4; i++) begin
      cyc_start();
      if (i == 0) begin
        valid = 1'b1; set_op(2'b10, 3'b100, 4'h0, 3'b000); prel = 16'h0040;
        q0.push_back(mk(2'b01, 1'b1, 16'h0040, 1'b1, 1'b0, 16'(exp_cnt)));
        exp_cnt++;
      end else begin
        valid = 1'b0;
        q0.push_back(mk(2'b00, 1'b0, 16'h0, (i < 3), (i < 3), 16'(exp_cnt)));
      end
      @(negedge clk);
      e = q0.pop_front(); o = obs0();
      checks++;
      if (o !== e) begin failures++; $display("FAIL jal cyc%0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_branch_sweep();
    exp_t e, o;
    br_t tbl[15];
    tbl = '{
      '{3'b111, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
      '{3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{3'b111, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{3'b111, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
      '{3'b111, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
      '{3'b111, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
      '{3'b111, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
      '{3'b111, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
      '{3'b111, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1},
      '{3'b111, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
      '{3'b111, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
      '{3'b111, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
      '{3'b111, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
      '{3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}
    };
    foreach (tbl[k]) begin
      cyc_start();
      valid = 1'b1; set_op(2'b10, tbl[k].op2, 4'h0, tbl[k].cond);
      s_f = tbl[k].s; z_f = tbl[k].z; c_f = tbl[k].c; v_f = tbl[k].v;
      prel = 16'h0100 + 16'(k);
      if (tbl[k].tk) q0.push_back(mk(2'b01, 1'b1, 16'h0100 + 16'(k), 1'b1, 1'b0, 16'(exp_cnt)));
      else           q0.push_back(mk(2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 16'(exp_cnt)));
      @(negedge clk);
      e = q0.pop_front(); o = obs0();
      checks++;
      if (o !== e) begin failures++; $display("FAIL branch row%0d: got %h want %h", k, o, e); end
      if (tbl[k].tk) begin
        exp_cnt++;
        for (int j = 0; j < 2; j++) begin
          cyc_start();
          valid = 1'b0;
          q0.push_back(mk(2'b00, 1'b0, 16'h0, 1'b1, 1'b1, 16'(exp_cnt)));
          @(negedge clk);
          e = q0.pop_front(); o = obs0();
          checks++;
          if (o !== e) begin failures++; $display("FAIL branch_flush row%0d f%0d: got %h want %h", k, j, o, e); end
        end
      end
    end
    s_f = 1'b0; z_f = 1'b0; c_f = 1'b0; v_f = 1'b0;
  endtask

  task automatic test_jalr_hold();
    exp_t e, o;
    int   stall_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      cyc_start();
      case (i)
        0: begin valid = 1'b1; hold = 1'b1; set_op(2'b11, 3'b000, 4'b1110, 3'b000); rtgt = 16'h1234; prel = 16'h5555;
                 q0.push_back(mk(2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 16'(exp_cnt))); end
        1: begin hold = 1'b0;
                 q0.push_back(mk(2'b10, 1'b1, 16'h1234, 1'b1, 1'b0, 16'(exp_cnt))); exp_cnt++; end
        2, 3, 4: begin valid = 1'b0; hold = 1'b1;
                 q0.push_back(mk(2'b00, 1'b0, 16'h0, 1'b1, 1'b1, 16'(exp_cnt))); end
        5, 6: begin hold = 1'b0;
                 q0.push_back(mk(2'b00, 1'b0, 16'h0, 1'b1, 1'b1, 16'(exp_cnt))); end
        default: q0.push_back(mk(2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 16'(exp_cnt)));
      endcase
      @(negedge clk);
      if (stall0 === 1'b1) stall_cycles++;
      e = q0.pop_front(); o = obs0();
      checks++;
      if (o !== e) begin failures++; $display("FAIL jalr_hold cyc%0d: got %h want %h", i, o, e); end
    end
    checks++;
    if (stall_cycles !== 6) begin failures++; $display("FAIL jalr_stall_total: got %0d want 6", stall_cycles); end
  endtask

  task automatic test_wrong_path();
    exp_t e, o;
    for (int i = 0; i < 7; i++) begin
      cyc_start();
      valid = (i < 4); set_op(2'b10, 3'b100, 4'h0, 3'b000); prel = 16'h0200 + 16'(i);
      if (i == 0 || i == 3) begin
        q0.push_back(mk(2'b01, 1'b1, 16'h0200 + 16'(i), 1'b1, 1'b0, 16'(exp_cnt)));
        exp_cnt++;
      end else if (i == 6) begin
        q0.push_back(mk(2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 16'(exp_cnt)));
      end else begin
        q0.push_back(mk(2'b00, 1'b0, 16'h0, 1'b1, 1'b1, 16'(exp_cnt)));
      end
      @(negedge clk);
      e = q0.pop_front(); o = obs0();
      checks++;
      if (o !== e) begin failures++; $display("FAIL wrong_path cyc%0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_back_to_back_sat();
    exp_t e, o;
    int   c1 = 0;
    valid = 1'b0;
    cyc_start();
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc_start();
      rst = 1'b0;
      valid1 = (i >= 1 && i <= 5); set_op(2'b10, 3'b100, 4'h0, 3'b000); prel = 16'h0ABC;
      if (valid1) begin
        q1.push_back(mk(2'b01, 1'b1, 16'h0ABC, 1'b1, 1'b0, 16'(c1)));
        if (c1 < 3) c1++;
      end else begin
        q1.push_back(mk(2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 16'(c1)));
      end
      @(negedge clk);
      e = q1.pop_front(); o = obs1();
      checks++;
      if (o !== e) begin failures++; $display("FAIL sat_noflush cyc%0d: got %h want %h", i, o, e); end
    end
    valid1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_jal();
    test_branch_sweep();
    test_jalr_hold();
    test_wrong_path();
    test_back_to_back_sat();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: q0=%0d q1=%0d want 0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Parametrised next-generation PC-source controller for the core's fetch stage. It decodes branch, JAL and JALR from the op fields and evaluates the full 8-code condition set against the S/Zero/C/V flags. It selects the PC source and redirect target, then holds stall for a configurable number of wrong-path flush cycles. It also counts taken redirects for performance monitoring.

Parameters:
XLEN, 16, width of PC and target buses
FLUSH_CYCLES, 2, extra stall cycles after the decision cycle of a taken redirect (0..15)
CNT_W, 16, width of the saturating redirect counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
valid  in  1  decode-stage instruction valid
hold  in  1  external pipeline freeze (memory wait); pauses this block
op1  in  2  major opcode
op2  in  3  sub-op (op1=10)
op3  in  4  sub-op (op1=11)
cond  in  3  branch condition code
S  in  1  sign flag
Zero  in  1  zero flag
C  in  1  carry flag
V  in  1  overflow flag
pc_rel_target  in  XLEN  PC-relative target (JAL/branch)
reg_target  in  XLEN  register target (JALR)
PCsrc  out  2  00 PC+1, 01 relative, 10 register
redirect  out  1  one-cycle pulse on an accepted taken redirect
redirect_pc  out  XLEN  selected target, valid when redirect=1
stall  out  1  fetch/decode stall
flushing  out  1  high while in FLUSH state
redirect_count  out  CNT_W  saturating count of accepted redirects

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, cnt=0, redirect_count=0. Outputs then: PCsrc=00, redirect=0, redirect_pc=0, stall=0, flushing=0. rst overrides all other inputs, including mid-FLUSH.
- Condition evaluation (combinational), true when:
  - 000 Zero
  - 001 S^V
  - 010 Zero|(S^V)
  - 011 ~Zero
  - 100 C
  - 101 ~C
  - 110 V
  - 111 always
- Decision:
  - JAL: op1=10, op2=100.
  - Branch: op1=10, op2=111, condition true.
  - JALR: op1=11, op3=1110.
  - take = state==IDLE & valid & ~hold & (JAL | taken branch | JALR).
- Decision cycle (combinational, same cycle as inputs): when take is high:
  - PCsrc=01 for JAL/branch, 10 for JALR.
  - redirect=1, stall=1.
  - redirect_pc = pc_rel_target or reg_target to match PCsrc.
  Otherwise PCsrc=00, redirect=0, redirect_pc=0.
- FSM, two states:
  - IDLE: on take with FLUSH_CYCLES>0, go to FLUSH and load cnt=FLUSH_CYCLES. On take with FLUSH_CYCLES=0, stay IDLE (stall for the decision cycle only).
  - FLUSH: stall=1, flushing=1, PCsrc=00, redirect=0. valid and op inputs are ignored (wrong-path). Each cycle with hold=0, cnt decrements; when cnt==1 and hold=0, return to IDLE next cycle. hold=1 freezes cnt and state.
- Total stall per taken redirect = 1 + FLUSH_CYCLES unfrozen cycles. Back-to-back redirects are impossible by construction; a redirect in the first IDLE cycle after a flush is allowed.
- hold=1 in IDLE suppresses take: no redirect, and stall reflects hold-only (stall=0 from this block).
- redirect_count increments at the posedge where take=1, and saturates at all-ones with no wrap.
- Not-taken branch and non-control ops: PCsrc=00, stall=0, no counter change.
- Flags C and V are now significant. Unused codes do not exist; all 8 are defined.

Test Plan:
- Reset: rst=1 for 2 cycles mid-FLUSH (cnt=1) -> next cycle state IDLE, stall=0, redirect_count=0, PCsrc=00.
- JAL, FLUSH_CYCLES=2, op1=10 op2=100 valid=1, pc_rel_target=0x0040 -> cycle0 PCsrc=01, redirect=1, redirect_pc=0x0040, stall=1. Cycles 1-2 stall=1, flushing=1. Cycle 3 stall=0. redirect_count=1.
- Branch cond sweep: op2=111 with each cond and flag combos (e.g. cond=100 C=1 -> taken; cond=101 C=1 -> not taken; cond=001 S=1 V=1 -> not taken; cond=111 -> taken) -> PCsrc/stall match the table.
- JALR with hold: op1=11 op3=1110, reg_target=0x1234, hold=1 for 1 cycle -> no redirect. Then hold=0 -> PCsrc=10, redirect_pc=0x1234. Then hold=1 during FLUSH for 3 cycles -> total stall = 1+2+3 = 6 cycles.
- Wrong-path ignore: valid JAL presented during FLUSH -> no redirect, counter unchanged. The same JAL in the first IDLE cycle -> redirect taken.
- Saturation and FLUSH_CYCLES=0, CNT_W=2: 5 taken JALs back-to-back -> stall high only on decision cycles, no FLUSH state, redirect_count stops at 3.
